nibble_serial_sender: RTL and testbench

Transmit-side counterpart to the button-request path. It accepts a request on a held-request / pulsed-acknowledge handshake, the same protocol the button press detectors use toward the up/down counter, with the sender acting as responder. On acceptance it latches a SIZE-bit data word, typically the counter value, and shifts it out on a single asynchronous-style serial line: start bit, data LSB first, optional even parity, stop bit. It sits in the slow (prescaled) clock domain next to the counter and drives an output pin or a downstream receiver.

---
 rtl/nibble_serial_sender.sv | 89 ++++++++
 tb/tb_nibble_serial_sender.sv | 117 +++++++++++
 2 files changed

// File: rtl/nibble_serial_sender.sv
// nibble_serial_sender: req/ack-accepted word sent as start, LSB-first data, optional even parity, stop.
module nibble_serial_sender #(
  parameter int SIZE       = 4,
  parameter int BIT_CYCLES = 10,
  parameter int PARITY     = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sendReq,
  input  logic [SIZE-1:0] data,
  output logic            sendAck,
  output logic            txLine,
  output logic            busy
);
  localparam int TW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [IW-1:0]   index, index_n;
  logic [SIZE-1:0] shift, shift_n, shr;
  logic            par, par_n, tx_n, busy_n, ack_n, bit_end;
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      index   <= '0;
      shift   <= '0;
      par     <= 1'b0;
      txLine  <= 1'b1;
      busy    <= 1'b0;
      sendAck <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      index   <= index_n;
      shift   <= shift_n;
      par     <= par_n;
      txLine  <= tx_n;
      busy    <= busy_n;
      sendAck <= ack_n;
    end
  end
  // Outputs are registered, so each branch sets the line level for the state being entered.
  always_comb begin
    bit_end = timer == TW'(BIT_CYCLES - 1);
    shr     = shift >> 1;
    state_n = state;
    timer_n = bit_end ? '0 : timer + 1'b1;
    index_n = index;
    shift_n = shift;
    par_n   = par;
    tx_n    = txLine;
    busy_n  = busy;
    ack_n   = 1'b0;
    case (state)
      S_START: if (bit_end) begin
        state_n = S_DATA;
        tx_n    = shift[0];
      end
      S_DATA: if (bit_end) begin
        if (index == IW'(SIZE - 1)) begin
          state_n = PARITY != 0 ? S_PAR : S_STOP;
          tx_n    = PARITY != 0 ? par : 1'b1;
        end else begin
          index_n = index + 1'b1;
          shift_n = shr;
          tx_n    = shr[0];
        end
      end
      S_PAR: if (bit_end) begin
        state_n = S_STOP;
        tx_n    = 1'b1;
      end
      default: ;
    endcase
    // The end of the stop bit counts as the first idle edge, so held requests chain frames with no gap.
    if (state == S_IDLE || (state == S_STOP && bit_end)) begin
      state_n = sendReq ? S_START : S_IDLE;
      timer_n = '0;
      index_n = '0;
      ack_n   = sendReq;
      busy_n  = sendReq;
      tx_n    = !sendReq;
      shift_n = sendReq ? data : shift;
      par_n   = sendReq ? ^data : par;
    end
  end
endmodule

// File: tb/tb_nibble_serial_sender.sv
// tb_nibble_serial_sender: table-driven frame checks on three parameterisations plus reset/back-to-back sequences.
module tb_nibble_serial_sender;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req [3];
  logic [3:0] dat [3];
  logic       ack [3];
  logic       tx  [3];
  logic       bsy [3];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  nibble_serial_sender #(.SIZE(4), .BIT_CYCLES(4), .PARITY(0)) dut0 (
    .clock(clk), .reset(rst), .sendReq(req[0]), .data(dat[0]),
    .sendAck(ack[0]), .txLine(tx[0]), .busy(bsy[0]));
  nibble_serial_sender #(.SIZE(4), .BIT_CYCLES(4), .PARITY(1)) dut1 (
    .clock(clk), .reset(rst), .sendReq(req[1]), .data(dat[1]),
    .sendAck(ack[1]), .txLine(tx[1]), .busy(bsy[1]));
  nibble_serial_sender #(.SIZE(1), .BIT_CYCLES(1), .PARITY(0)) dut2 (
    .clock(clk), .reset(rst), .sendReq(req[2]), .data(dat[2][0]),
    .sendAck(ack[2]), .txLine(tx[2]), .busy(bsy[2]));
  typedef struct {
    int         s;
    int         bc;
    int         nb;
    logic [3:0] d;
    logic [6:0] bits;
  } vec_t;
  vec_t tbl [8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic accept(input int s, input logic [3:0] d);
    dat[s] = d;
    req[s] = 1'b1;
    tick();
  endtask
  // Called in the ack cycle; bits[i] is the i-th transmitted bit, start bit first.
  task automatic body(input int s, input int bc, input int nb, input logic [6:0] bits,
                      input logic hold, input logic [3:0] nd);
    chk("ack_pulse", ack[s], 1'b1);
    if (!hold) req[s] = 1'b0;
    for (int i = 0; i < nb; i++)
      for (int c = 0; c < bc; c++) begin
        if (i == 1 && c == 0) dat[s] = nd;
        chk($sformatf("tx_d%0d_b%0d_c%0d", s, i, c), tx[s], bits[i]);
        chk($sformatf("busy_d%0d_b%0d_c%0d", s, i, c), bsy[s], 1'b1);
        if (i != 0 || c != 0) chk($sformatf("ack_low_d%0d_b%0d", s, i), ack[s], 1'b0);
        tick();
      end
    if (!hold) begin
      chk("idle_busy", bsy[s], 1'b0);
      chk("idle_tx", tx[s], 1'b1);
      chk("idle_ack", ack[s], 1'b0);
    end
  endtask
  initial begin
    tbl[0] = '{0, 4, 6, 4'b1011, 7'b0110110};
    tbl[1] = '{0, 4, 6, 4'b0110, 7'b0101100};
    tbl[2] = '{0, 4, 6, 4'b1000, 7'b0110000};
    tbl[3] = '{1, 4, 7, 4'b1011, 7'b1110110};
    tbl[4] = '{1, 4, 7, 4'b0011, 7'b1000110};
    tbl[5] = '{1, 4, 7, 4'b0111, 7'b1101110};
    tbl[6] = '{2, 1, 3, 4'b0001, 7'b0000110};
    tbl[7] = '{2, 1, 3, 4'b0000, 7'b0000100};
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b1;
      dat[k] = 4'h0;
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_tx%0d", k), tx[k], 1'b1);
        chk($sformatf("rst_busy%0d", k), bsy[k], 1'b0);
        chk($sformatf("rst_ack%0d", k), ack[k], 1'b0);
      end
    end
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    rst = 1'b0;
    tick();
    for (int v = 0; v < 8; v++) begin
      accept(tbl[v].s, tbl[v].d);
      body(tbl[v].s, tbl[v].bc, tbl[v].nb, tbl[v].bits, 1'b0, tbl[v].d);
      tick();
    end
    accept(0, 4'b1011);
    body(0, 4, 6, 7'b0110110, 1'b0, 4'h0);
    tick();
    accept(0, 4'hF);
    body(0, 4, 6, 7'b0111110, 1'b1, 4'h0);
    body(0, 4, 6, 7'b0100000, 1'b0, 4'h0);
    tick();
    accept(0, 4'b1011);
    req[0] = 1'b0;
    for (int n = 1; n < 10; n++) tick();
    rst = 1'b1;
    tick();
    chk("abort_tx", tx[0], 1'b1);
    chk("abort_busy", bsy[0], 1'b0);
    chk("abort_ack", ack[0], 1'b0);
    rst = 1'b0;
    tick();
    chk("abort_idle_tx", tx[0], 1'b1);
    accept(0, 4'b0110);
    body(0, 4, 6, 7'b0101100, 1'b0, 4'b0110);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
